end_perm_stage: RTL

Registered output stage at the end of the Ascon permutation path. It applies the end-of-permutation XORs (key into words 3/4, domain-separation bit) and holds the result in a one-deep valid/ready buffer. On finalization it extracts and registers the 128-bit tag and optionally compares it with an expected tag for decryption. It sits between the permutation datapath and the state register / top-level FSM, mirroring the begin-of-permutation XOR on the output side.

---
 rtl/end_perm_stage_if.sv | 55 +++++
 rtl/end_perm_stage.sv | 111 +++++++++++
 2 files changed

// File: rtl/end_perm_stage_if.sv
// ascon_pack / end_perm_stage_if
//
// Purpose: the shared Ascon state type and the valid/ready bus around the
// end-of-permutation output stage.
//
// type_state holds the five 64-bit Ascon words. Word k is element [k].
//
// Bus signal summary (directions are as seen from the stage, via the slave modport):
//   valid_i, state_i        upstream beat and its permutation-output state
//   en_xor_key_i            XOR key into words 3/4
//   en_xor_lsb_i            XOR 1 into bit 0 of word 4
//   en_tag_i, en_verify_i   finalization beat / compare against tag_exp_i
//   key_i, tag_exp_i        128-bit key and expected tag
//   ready_o                 stage can take a beat this cycle
//   valid_o, state_o        buffered beat towards the state register
//   ready_i                 downstream accepts state_o
//   tag_o, tag_valid_o      registered tag, and whether it belongs to state_o
//   tag_ok_o                last verification result
package ascon_pack;
  typedef logic [4:0][63:0] type_state;
endpackage

interface end_perm_stage_if;
  import ascon_pack::*;

  logic          valid_i;
  logic          ready_o;
  type_state     state_i;
  logic          en_xor_key_i;
  logic          en_xor_lsb_i;
  logic          en_tag_i;
  logic          en_verify_i;
  logic [127:0]  key_i;
  logic [127:0]  tag_exp_i;
  logic          valid_o;
  logic          ready_i;
  type_state     state_o;
  logic [127:0]  tag_o;
  logic          tag_valid_o;
  logic          tag_ok_o;

  // Producer/consumer side (permutation datapath + state register)
  modport master (
    output valid_i, state_i, en_xor_key_i, en_xor_lsb_i, en_tag_i,
           en_verify_i, key_i, tag_exp_i, ready_i,
    input  ready_o, valid_o, state_o, tag_o, tag_valid_o, tag_ok_o
  );

  // The output stage itself
  modport slave (
    input  valid_i, state_i, en_xor_key_i, en_xor_lsb_i, en_tag_i,
           en_verify_i, key_i, tag_exp_i, ready_i,
    output ready_o, valid_o, state_o, tag_o, tag_valid_o, tag_ok_o
  );
endinterface

// File: rtl/end_perm_stage.sv
// end_perm_stage
//
// Purpose: applies the end-of-permutation XORs (key into words 3/4 and the
// domain-separation bit) and holds the result in a one-deep valid/ready
// buffer. On a finalization beat it registers the 128-bit tag {w3, w4} and,
// for decryption, the outcome of comparing it with the expected tag.
//
// Ports:
//   clock_i   system clock, rising edge
//   resetb_i  asynchronous active-low reset
//   bus       end_perm_stage_if.slave (handshake, state, key, tag)
//
// There is no skid buffer: ready_o is a combinational pass-through of
// downstream ready whenever the buffer is occupied.
module end_perm_stage
  import ascon_pack::*;
(
  input logic             clock_i,
  input logic             resetb_i,
  end_perm_stage_if.slave bus
);

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } fsm_t;

  fsm_t         r_fsm;
  fsm_t         w_fsm_next;
  logic         w_ready;
  logic         w_valid;
  logic         w_accept;
  logic [63:0]  w_word3;
  logic [63:0]  w_word4;
  logic [127:0] w_tag;

  type_state    r_state;
  logic [127:0] r_tag;
  logic         r_tag_valid;
  logic         r_tag_ok;

  // Output-side XORs; both may apply on the same beat.
  always_comb begin
    w_word3 = bus.state_i[3];
    w_word4 = bus.state_i[4];
    if (bus.en_xor_key_i) begin
      w_word3 = w_word3 ^ bus.key_i[127:64];
      w_word4 = w_word4 ^ bus.key_i[63:0];
    end
    w_word4[0] = w_word4[0] ^ bus.en_xor_lsb_i;
    w_tag      = {w_word3, w_word4};
  end

  // Next state and handshake outputs.
  always_comb begin
    w_fsm_next = r_fsm;
    w_ready    = 1'b1;
    w_valid    = 1'b0;
    case (r_fsm)
      ST_EMPTY: begin
        if (bus.valid_i) w_fsm_next = ST_FULL;
      end
      ST_FULL: begin
        w_valid = 1'b1;
        w_ready = bus.ready_i;
        if (bus.ready_i && !bus.valid_i) w_fsm_next = ST_EMPTY;
      end
      default: w_fsm_next = ST_EMPTY;
    endcase
  end

  assign w_accept = bus.valid_i & w_ready;

  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) r_fsm <= ST_EMPTY;
    else           r_fsm <= w_fsm_next;
  end

  // Buffer and tag registers. tag_o/tag_ok_o move only on an accepted tag
  // beat; tag_valid_o also clears when the tag beat drains without a
  // replacement.
  always_ff @(posedge clock_i or negedge resetb_i) begin
    if (!resetb_i) begin
      r_state     <= '0;
      r_tag       <= '0;
      r_tag_valid <= 1'b0;
      r_tag_ok    <= 1'b0;
    end else if (w_accept) begin
      r_state[0]  <= bus.state_i[0];
      r_state[1]  <= bus.state_i[1];
      r_state[2]  <= bus.state_i[2];
      r_state[3]  <= w_word3;
      r_state[4]  <= w_word4;
      r_tag_valid <= bus.en_tag_i;
      if (bus.en_tag_i) begin
        r_tag    <= w_tag;
        r_tag_ok <= bus.en_verify_i && (w_tag == bus.tag_exp_i);
      end
    end else if (r_fsm == ST_FULL && bus.ready_i) begin
      r_tag_valid <= 1'b0;
    end
  end

  assign bus.ready_o     = w_ready;
  assign bus.valid_o     = w_valid;
  assign bus.state_o     = r_state;
  assign bus.tag_o       = r_tag;
  assign bus.tag_valid_o = r_tag_valid;
  assign bus.tag_ok_o    = r_tag_ok;

endmodule
